// File: rtl/vx_csr_req_unit_if.sv
// CSR request unit bundle: issue-side request, CSR data block read/write strobes,
// and commit-side response. master = the request unit, slave = its surroundings.
`ifndef UUID_BITS
`define UUID_BITS 44
`endif
`ifndef NW_BITS
`define NW_BITS 2
`endif
`ifndef CSR_ADDR_BITS
`define CSR_ADDR_BITS 12
`endif
`ifndef NR_BITS
`define NR_BITS 5
`endif

interface vx_csr_req_unit_if #(
  parameter int CSR_OPS_BITS = 2
);
  logic                      req_valid;
  logic                      req_ready;
  logic [`UUID_BITS-1:0]     req_uuid;
  logic [`NW_BITS-1:0]       req_wid;
  logic [`CSR_ADDR_BITS-1:0] req_addr;
  logic [CSR_OPS_BITS-1:0]   req_op;
  logic [31:0]               req_src;
  logic                      req_src_zero;
  logic [`NR_BITS-1:0]       req_rd;
  logic                      req_wb;

  logic                      read_enable;
  logic [`UUID_BITS-1:0]     read_uuid;
  logic [`CSR_ADDR_BITS-1:0] read_addr;
  logic [`NW_BITS-1:0]       read_wid;
  logic [31:0]               read_data;

  logic                      write_enable;
  logic [`UUID_BITS-1:0]     write_uuid;
  logic [`CSR_ADDR_BITS-1:0] write_addr;
  logic [`NW_BITS-1:0]       write_wid;
  logic [31:0]               write_data;

  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [`UUID_BITS-1:0]     rsp_uuid;
  logic [`NW_BITS-1:0]       rsp_wid;
  logic [`NR_BITS-1:0]       rsp_rd;
  logic                      rsp_wb;
  logic [31:0]               rsp_data;
  logic                      busy;

  modport master (
    input  req_valid, req_uuid, req_wid, req_addr, req_op, req_src, req_src_zero, req_rd, req_wb,
    output req_ready,
    output read_enable, read_uuid, read_addr, read_wid,
    input  read_data,
    output write_enable, write_uuid, write_addr, write_wid, write_data,
    output rsp_valid, rsp_uuid, rsp_wid, rsp_rd, rsp_wb, rsp_data,
    input  rsp_ready,
    output busy
  );

  modport slave (
    output req_valid, req_uuid, req_wid, req_addr, req_op, req_src, req_src_zero, req_rd, req_wb,
    input  req_ready,
    input  read_enable, read_uuid, read_addr, read_wid,
    output read_data,
    input  write_enable, write_uuid, write_addr, write_wid, write_data,
    input  rsp_valid, rsp_uuid, rsp_wid, rsp_rd, rsp_wb, rsp_data,
    output rsp_ready,
    input  busy
  );
endinterface

// File: rtl/vx_csr_req_unit.sv
// CSR read-modify-write initiator: combinational read in S0, one write and the
// old-value response from the single S1 entry, with same-address forwarding.
`ifndef UUID_BITS
`define UUID_BITS 44
`endif
`ifndef NW_BITS
`define NW_BITS 2
`endif
`ifndef CSR_ADDR_BITS
`define CSR_ADDR_BITS 12
`endif
`ifndef NR_BITS
`define NR_BITS 5
`endif

module vx_csr_req_unit #(
  parameter int CORE_ID      = 0,
  parameter int CSR_OPS_BITS = 2
) (
  input  logic              clk,
  input  logic              reset,
  vx_csr_req_unit_if.master csr
);
  localparam logic [CSR_OPS_BITS-1:0] OP_RW  = CSR_OPS_BITS'(0);
  localparam logic [CSR_OPS_BITS-1:0] OP_RS  = CSR_OPS_BITS'(1);
  localparam logic [CSR_OPS_BITS-1:0] OP_RC  = CSR_OPS_BITS'(2);
  localparam logic [CSR_OPS_BITS-1:0] OP_ILL = CSR_OPS_BITS'(3);

  typedef struct packed {
    logic [31:0]               old_val;
    logic [31:0]               new_val;
    logic                      wr;
    logic [`CSR_ADDR_BITS-1:0] addr;
    logic [`NW_BITS-1:0]       wid;
    logic [`UUID_BITS-1:0]     uuid;
    logic [`NR_BITS-1:0]       rd;
    logic                      wb;
  } s1_t;

  s1_t         s0, s1_q;
  logic        s1_valid, s1_written;
  logic        accept, bypass;
  logic [31:0] old_val;

  assign csr.req_ready   = ~s1_valid | (csr.rsp_ready & s1_valid);
  assign accept          = csr.req_valid & csr.req_ready;

  assign csr.read_enable = accept;
  assign csr.read_uuid   = csr.req_uuid;
  assign csr.read_addr   = csr.req_addr;
  assign csr.read_wid    = csr.req_wid;

  // The CSR block only sees S1's write at the closing edge of this cycle, so a
  // matching request accepted now must take the pending value instead.
  assign bypass  = s1_valid & s1_q.wr & ~s1_written
                 & (s1_q.addr == csr.req_addr) & (s1_q.wid == csr.req_wid);
  assign old_val = bypass ? s1_q.new_val : csr.read_data;

  always_comb begin
    s0         = '0;
    s0.old_val = old_val;
    s0.addr    = csr.req_addr;
    s0.wid     = csr.req_wid;
    s0.uuid    = csr.req_uuid;
    s0.rd      = csr.req_rd;
    s0.wb      = csr.req_wb;
    s0.wr      = (csr.req_op == OP_RW) | ~csr.req_src_zero;
    case (csr.req_op)
      OP_RW:   s0.new_val = csr.req_src;
      OP_RS:   s0.new_val = old_val | csr.req_src;
      OP_RC:   s0.new_val = old_val & ~csr.req_src;
      default: begin
        s0.new_val = old_val | csr.req_src;
        s0.wr      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid   <= 1'b0;
      s1_written <= 1'b0;
      s1_q       <= '0;
    end else if (accept) begin
      s1_valid   <= 1'b1;
      s1_written <= 1'b0;
      s1_q       <= s0;
    end else begin
      if (csr.rsp_ready & s1_valid) s1_valid <= 1'b0;
      // Keeps the write to one pulse while the response is held back.
      if (s1_valid) s1_written <= 1'b1;
    end
  end

  assign csr.write_enable = s1_valid & s1_q.wr & ~s1_written;
  assign csr.write_uuid   = s1_q.uuid;
  assign csr.write_addr   = s1_q.addr;
  assign csr.write_wid    = s1_q.wid;
  assign csr.write_data   = s1_q.new_val;

  assign csr.rsp_valid = s1_valid;
  assign csr.rsp_uuid  = s1_q.uuid;
  assign csr.rsp_wid   = s1_q.wid;
  assign csr.rsp_rd    = s1_q.rd;
  assign csr.rsp_wb    = s1_q.wb;
  assign csr.rsp_data  = s1_q.old_val;
  assign csr.busy      = s1_valid;

  a_legal_op: assert property (@(posedge clk) disable iff (!reset)
    accept |-> (csr.req_op != OP_ILL))
    else $error("core%0d: reserved CSR op accepted", CORE_ID);
endmodule

// File: doc/vx_csr_req_unit.md
Name: vx_csr_req_unit

Overview:
- Initiator side of the per-core CSR read/write port; executes CSRRW/CSRRS/CSRRC and their immediate forms as read-modify-write.
- Sits between issue and commit: takes a CSR request, issues a combinational read to the CSR data block, computes the new value, and issues one write.
- Returns the old value for writeback.
- Provides same-address forwarding so back-to-back accesses never see stale data.

Parameters:
- CORE_ID, 0, core index; carried only for debug messages.
- CSR_OPS_BITS, 2, width of the op code: 0=RW, 1=RS, 2=RC, 3 reserved.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- req_valid  in  1  request valid
- req_ready  out  1  request accepted when valid&ready
- req_uuid  in  `UUID_BITS  instruction id
- req_wid  in  `NW_BITS  warp id
- req_addr  in  `CSR_ADDR_BITS  CSR address
- req_op  in  CSR_OPS_BITS  RW/RS/RC
- req_src  in  32  rs1 value or zero-extended uimm
- req_src_zero  in  1  rs1==x0 or uimm==0
- req_rd  in  `NR_BITS  destination register
- req_wb  in  1  rd!=x0
- read_enable  out  1  CSR read strobe
- read_uuid  out  `UUID_BITS  read instruction id
- read_addr  out  `CSR_ADDR_BITS  read address
- read_wid  out  `NW_BITS  read warp id
- read_data  in  32  combinational read result
- write_enable  out  1  CSR write strobe
- write_uuid  out  `UUID_BITS  write instruction id
- write_addr  out  `CSR_ADDR_BITS  write address
- write_wid  out  `NW_BITS  write warp id
- write_data  out  32  write value
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumed
- rsp_uuid  out  `UUID_BITS  response instruction id
- rsp_wid  out  `NW_BITS  response warp id
- rsp_rd  out  `NR_BITS  response destination register
- rsp_wb  out  1  writeback enable
- rsp_data  out  32  old CSR value
- busy  out  1  request in flight

Behaviour:
- Two stages.
  - S0 is combinational on the request port.
  - S1 is a single registered entry: s1_valid, s1_written, old, new, wr, addr, wid, uuid, rd, wb.
- read_enable = req_valid & req_ready; read_addr/wid/uuid are wired straight from req_*.
- old_val:
  - Bypass when s1_valid & s1_wr & ~s1_written & s1_addr==req_addr & s1_wid==req_wid; old_val = s1_new.
  - Otherwise old_val = read_data.
- new value:
  - RW: src.
  - RS: old|src.
  - RC: old&~src.
  - All arithmetic is 32-bit.
- wr = (op==RW) | ~req_src_zero. RS/RC with a zero source never writes; RW always writes.
- op==3 is illegal and must be flagged by assertion on accept. It is treated as RS with wr=0.
- req_ready = ~s1_valid | (rsp_ready & rsp_valid).
- On accept: S1 loads all fields and clears s1_written. Without an accept, s1_valid clears when the response handshakes.
- write_enable = s1_valid & s1_wr & ~s1_written. Write fields come from S1.
  - s1_written sets on the cycle after s1_valid goes high.
  - Exactly one write per instruction, even under response backpressure.
- Write is issued in the first S1 cycle, one cycle after accept. The CSR block updates at that edge.
  - A new request accepted in that same cycle to the same addr/wid takes the bypass.
  - From the next cycle, read_data is current.
- rsp_valid = s1_valid. rsp_data = s1_old, rsp_uuid/wid/rd/wb from S1. The response is held stable while ~rsp_ready.
- Latency: response is visible 1 cycle after accept. Throughput is 1 per cycle when rsp_ready=1.
- busy = s1_valid.
- Reset (asynchronous, active-low):
  - s1_valid=0, s1_written=0; all data registers cleared.
  - Outputs: req_ready=1, write_enable=0, rsp_valid=0, busy=0, read_enable follows req_valid.
- Reset mid-operation: a pending unissued write is dropped. No write_enable may pulse during reset or in the first cycle after release.

Test Plan:
- RW: csr 0x340 holds 0x5, RW src=0xA -> rsp_data=0x5, write_enable 1 cycle later with data 0xA, rsp_valid same cycle.
- RS/RC: csr=0xF0. RS src=0x0F -> write 0xFF, rsp 0xF0. Then RC src=0x30 -> write 0xCF, rsp 0xFF.
- Zero source: RS with req_src_zero=1 on csr=0x12 -> rsp_data=0x12, write_enable never asserted.
- Back-to-back forwarding: RW 0x1 then immediate RS 0x2, same addr/wid, rsp_ready=1 -> second rsp_data=0x1, second write 0x3. A different wid gets no bypass.
- Backpressure: rsp_ready=0 for 5 cycles -> exactly one write_enable pulse, req_ready=0, rsp fields stable; accept resumes on handshake.
- Reset: assert reset the cycle after accept, before the write cycle -> no write_enable, rsp_valid=0, busy=0; normal operation after release.
